// File: rtl/sdp_ctrl_pkg.sv
// Shared helpers for the sdp_bram controller family: sizing functions,
// read-latency derivation and the packed-address slice macro.
`ifndef SDP_CTRL_PKG_SV
`define SDP_CTRL_PKG_SV

// Selects element idx of width w from a flat packed vector.
`define SDP_ADDR_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]

package sdp_ctrl_pkg;

  // Number of bits needed to hold the value depth.
  function automatic int clogb2(input int depth);
    int d;
    int r;
    d = depth;
    for (r = 0; d > 0; r++) begin
      d = d >> 1;
    end
    return r;
  endfunction

  // Requester ID width, never narrower than one bit.
  function automatic int id_width(input int num_req);
    int w;
    w = clogb2(num_req - 1);
    return (w < 1) ? 1 : w;
  endfunction

  // BRAM read latency: the output register adds a cycle in HIGH_PERFORMANCE.
  function automatic int rd_lat_of(input string perf);
    return (perf == "LOW_LATENCY") ? 1 : 2;
  endfunction

endpackage

`endif

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible index after rr_ptr,
// wrapping modulo NUM_REQ. The pointer register lives in the parent.
module rr_arbiter
  import sdp_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    winner
);

  logic [ID_W-1:0] sel;
  logic            found;

  // Scan cyclically starting just past the previous winner.
  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    sel    = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      sel = ID_W'((int'(rr_ptr) + off) % NUM_REQ);
      if (!found && eligible[sel]) begin
        found       = 1'b1;
        grant[sel]  = 1'b1;
        winner      = sel;
      end
    end
  end

endmodule

// File: rtl/sdp_bram_rd_arbiter.sv
// Shares the sdp_bram read port among NUM_REQ requesters with round-robin
// arbitration, tracks the BRAM read latency and tags responses with the
// requester ID. Reads colliding with a same-cycle write are held off.
module sdp_bram_rd_arbiter
  import sdp_ctrl_pkg::*;
#(
  parameter int    NUM_REQ         = 4,
  parameter int    RAM_WIDTH       = 32,
  parameter int    RAM_DEPTH       = 256,
  parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE",
  parameter int    ADDR_W          = clogb2(RAM_DEPTH - 1),
  parameter int    ID_W            = id_width(NUM_REQ)
) (
  input  logic                      clka,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [RAM_WIDTH-1:0]      wr_data,
  output logic                      bram_wea,
  output logic [ADDR_W-1:0]         bram_addra,
  output logic [RAM_WIDTH-1:0]      bram_dina,
  output logic                      bram_enb,
  output logic [ADDR_W-1:0]         bram_addrb,
  output logic                      bram_regceb,
  output logic                      bram_rstb,
  input  logic [RAM_WIDTH-1:0]      bram_doutb,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [RAM_WIDTH-1:0]      rsp_data
);

  localparam int RD_LAT = rd_lat_of(RAM_PERFORMANCE);

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    winner_id;
  logic [ID_W-1:0]    rr_ptr_reg;
  logic [ADDR_W-1:0]  addr_hold_reg;
  logic [ADDR_W-1:0]  win_addr;
  logic [RD_LAT-1:0]  vld_reg;
  logic [ID_W-1:0]    id_reg [RD_LAT];

  // A request is eligible unless it targets the address being written this
  // cycle; nothing is granted while reset is asserted.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_elig
      assign eligible[gi] = rst_n & req_valid[gi] &
                            ~(wr_en & (`SDP_ADDR_SLICE(req_addr, gi, ADDR_W) == wr_addr));
    end
  endgenerate

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .eligible (eligible),
    .rr_ptr   (rr_ptr_reg),
    .grant    (grant),
    .winner   (winner_id)
  );

  assign win_addr   = `SDP_ADDR_SLICE(req_addr, int'(winner_id), ADDR_W);
  assign req_ready  = grant;
  assign bram_enb   = |grant;
  assign bram_addrb = bram_enb ? win_addr : addr_hold_reg;

  // Write port is a straight pass-through; writes are never stalled.
  assign bram_wea   = wr_en;
  assign bram_addra = wr_addr;
  assign bram_dina  = wr_data;
  assign bram_rstb  = ~rst_n;

  // Advance the priority pointer and remember the last read address.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg    <= ID_W'(NUM_REQ - 1);
      addr_hold_reg <= '0;
    end else if (bram_enb) begin
      rr_ptr_reg    <= winner_id;
      addr_hold_reg <= win_addr;
    end
  end

  // Valid/ID shift pipeline matching the BRAM read latency.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      vld_reg <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        id_reg[i] <= '0;
      end
    end else begin
      vld_reg[0] <= bram_enb;
      id_reg[0]  <= winner_id;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_reg[i] <= vld_reg[i-1];
        id_reg[i]  <= id_reg[i-1];
      end
    end
  end

  // The output register only exists in the two-cycle configuration.
  assign bram_regceb = (RD_LAT == 2) ? vld_reg[0] : 1'b0;
  assign rsp_valid   = vld_reg[RD_LAT-1];
  assign rsp_id      = id_reg[RD_LAT-1];
  assign rsp_data    = bram_doutb;

endmodule

// File: tb/tb_sdp_bram_rd_arbiter.sv
// Directed bench for sdp_bram_rd_arbiter: one HIGH_PERFORMANCE and one
// LOW_LATENCY instance share the stimulus, each with its own BRAM model.
module tb_sdp_bram_rd_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;

  // HIGH_PERFORMANCE instance signals
  logic [N-1:0]  hp_ready;
  logic          hp_wea, hp_enb, hp_regceb, hp_rstb, hp_rsp_valid;
  logic [AW-1:0] hp_addra, hp_addrb;
  logic [DW-1:0] hp_dina, hp_doutb, hp_rsp_data, hp_ram_q;
  logic [IW-1:0] hp_rsp_id;
  logic [DW-1:0] mem_hp [256];

  // LOW_LATENCY instance signals
  logic [N-1:0]  ll_ready;
  logic          ll_wea, ll_enb, ll_regceb, ll_rstb, ll_rsp_valid;
  logic [AW-1:0] ll_addra, ll_addrb;
  logic [DW-1:0] ll_dina, ll_doutb, ll_rsp_data, ll_ram_q;
  logic [IW-1:0] ll_rsp_id;
  logic [DW-1:0] mem_ll [256];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sdp_bram_rd_arbiter #(
    .NUM_REQ(N), .RAM_WIDTH(DW), .RAM_DEPTH(256), .RAM_PERFORMANCE("HIGH_PERFORMANCE")
  ) dut_hp (
    .clka(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(hp_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .bram_wea(hp_wea), .bram_addra(hp_addra), .bram_dina(hp_dina),
    .bram_enb(hp_enb), .bram_addrb(hp_addrb), .bram_regceb(hp_regceb),
    .bram_rstb(hp_rstb), .bram_doutb(hp_doutb), .rsp_valid(hp_rsp_valid),
    .rsp_id(hp_rsp_id), .rsp_data(hp_rsp_data)
  );

  sdp_bram_rd_arbiter #(
    .NUM_REQ(N), .RAM_WIDTH(DW), .RAM_DEPTH(256), .RAM_PERFORMANCE("LOW_LATENCY")
  ) dut_ll (
    .clka(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(ll_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .bram_wea(ll_wea), .bram_addra(ll_addra), .bram_dina(ll_dina),
    .bram_enb(ll_enb), .bram_addrb(ll_addrb), .bram_regceb(ll_regceb),
    .bram_rstb(ll_rstb), .bram_doutb(ll_doutb), .rsp_valid(ll_rsp_valid),
    .rsp_id(ll_rsp_id), .rsp_data(ll_rsp_data)
  );

  // Read-first BRAM with output register
  always @(posedge clk) begin
    if (hp_wea) mem_hp[hp_addra] <= hp_dina;
    if (hp_enb) hp_ram_q <= mem_hp[hp_addrb];
    if (hp_rstb) hp_doutb <= '0;
    else if (hp_regceb) hp_doutb <= hp_ram_q;
  end

  // Read-first BRAM without output register
  always @(posedge clk) begin
    if (ll_wea) mem_ll[ll_addra] <= ll_dina;
    if (ll_rstb) ll_ram_q <= '0;
    else if (ll_enb) ll_ram_q <= mem_ll[ll_addrb];
  end
  assign ll_doutb = ll_ram_q;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  logic [AW-1:0] pre_addr [9] = '{8'h05, 8'h10, 8'h20, 8'h30, 8'h31, 8'h40, 8'h41, 8'h42, 8'h43};
  logic [DW-1:0] pre_data [9] = '{32'hDEADBEEF, 32'hA0A00010, 32'hB0B00020, 32'hFFFF0000,
                                  32'hCAFE0031, 32'h00001000, 32'h00001001, 32'h00001002,
                                  32'h00001003};
  int gcount [N];

  initial begin
    rst_n = 1'b0; req_valid = '0; req_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    tick(); tick();

    // Reset state
    check("rst_ready", 64'(hp_ready), 64'h0);
    check("rst_enb", 64'(hp_enb), 64'h0);
    check("rst_regceb", 64'(hp_regceb), 64'h0);
    check("rst_rsp_valid", 64'(hp_rsp_valid), 64'h0);
    check("rst_rsp_id", 64'(hp_rsp_id), 64'h0);
    check("rst_bram_rstb", 64'(hp_rstb), 64'h1);
    $display("reset: ready=%b enb=%b rsp_valid=%b", hp_ready, hp_enb, hp_rsp_valid);
    rst_n = 1'b1;
    tick();

    // Preload through the write pass-through
    for (int k = 0; k < 9; k++) begin
      wr_en = 1'b1; wr_addr = pre_addr[k]; wr_data = pre_data[k];
      #1;
      if (k == 0) begin
        check("wr_pass_wea", 64'(hp_wea), 64'h1);
        check("wr_pass_addra", 64'(hp_addra), 64'h05);
        check("wr_pass_dina", 64'(hp_dina), 64'hDEADBEEF);
      end
      $display("preload: addr=%02h data=%08h", pre_addr[k], pre_data[k]);
      tick();
    end
    wr_en = 1'b0;
    tick();

    // Scenario 1: single read of 0x05 by requester 0
    req_valid = 4'b0001; set_addr(0, 8'h05);
    #1;
    check("s1_ready", 64'(hp_ready), 64'h1);
    check("s1_enb", 64'(hp_enb), 64'h1);
    check("s1_addrb", 64'(hp_addrb), 64'h05);
    check("s1_ll_ready", 64'(ll_ready), 64'h1);
    $display("s1 grant: ready=%b addrb=%02h", hp_ready, hp_addrb);
    tick();
    req_valid = '0; set_addr(0, 8'h77);
    #1;
    check("s1_idle_enb", 64'(hp_enb), 64'h0);
    check("s1_addrb_hold", 64'(hp_addrb), 64'h05);
    check("s1_hp_regceb", 64'(hp_regceb), 64'h1);
    check("s1_hp_early", 64'(hp_rsp_valid), 64'h0);
    check("s1_ll_rsp_valid", 64'(ll_rsp_valid), 64'h1);
    check("s1_ll_rsp_id", 64'(ll_rsp_id), 64'h0);
    check("s1_ll_rsp_data", 64'(ll_rsp_data), 64'hDEADBEEF);
    check("s1_ll_regceb", 64'(ll_regceb), 64'h0);
    $display("s1 ll rsp: valid=%b id=%0d data=%08h", ll_rsp_valid, ll_rsp_id, ll_rsp_data);
    tick();
    check("s1_hp_rsp_valid", 64'(hp_rsp_valid), 64'h1);
    check("s1_hp_rsp_id", 64'(hp_rsp_id), 64'h0);
    check("s1_hp_rsp_data", 64'(hp_rsp_data), 64'hDEADBEEF);
    check("s1_ll_done", 64'(ll_rsp_valid), 64'h0);
    check("s1_ll_regceb2", 64'(ll_regceb), 64'h0);
    $display("s1 hp rsp: valid=%b id=%0d data=%08h", hp_rsp_valid, hp_rsp_id, hp_rsp_data);
    tick();
    check("s1_hp_done", 64'(hp_rsp_valid), 64'h0);

    // Scenario 2: requesters 1 and 2 together
    req_valid = 4'b0110; set_addr(1, 8'h10); set_addr(2, 8'h20);
    #1;
    check("s2_grant1", 64'(hp_ready), 64'b0010);
    check("s2_addrb1", 64'(hp_addrb), 64'h10);
    tick();
    req_valid = 4'b0100;
    #1;
    check("s2_grant2", 64'(hp_ready), 64'b0100);
    check("s2_addrb2", 64'(hp_addrb), 64'h20);
    tick();
    req_valid = '0;
    #1;
    check("s2_rsp1_valid", 64'(hp_rsp_valid), 64'h1);
    check("s2_rsp1_id", 64'(hp_rsp_id), 64'h1);
    check("s2_rsp1_data", 64'(hp_rsp_data), 64'hA0A00010);
    $display("s2 rsp: id=%0d data=%08h", hp_rsp_id, hp_rsp_data);
    tick();
    check("s2_rsp2_valid", 64'(hp_rsp_valid), 64'h1);
    check("s2_rsp2_id", 64'(hp_rsp_id), 64'h2);
    check("s2_rsp2_data", 64'(hp_rsp_data), 64'hB0B00020);
    $display("s2 rsp: id=%0d data=%08h", hp_rsp_id, hp_rsp_data);
    tick();

    // Scenario 4: read of 0x30 collides with a write to 0x30
    wr_en = 1'b1; wr_addr = 8'h30; wr_data = 32'h00001234;
    req_valid = 4'b0011; set_addr(0, 8'h30); set_addr(1, 8'h31);
    #1;
    check("s4_grant_req1", 64'(hp_ready), 64'b0010);
    check("s4_wea", 64'(hp_wea), 64'h1);
    $display("s4 collide: ready=%b wea=%b", hp_ready, hp_wea);
    tick();
    wr_en = 1'b0; req_valid = 4'b0001;
    #1;
    check("s4_grant_req0", 64'(hp_ready), 64'b0001);
    check("s4_addrb", 64'(hp_addrb), 64'h30);
    tick();
    req_valid = '0;
    #1;
    check("s4_rsp1_id", 64'(hp_rsp_id), 64'h1);
    check("s4_rsp1_data", 64'(hp_rsp_data), 64'hCAFE0031);
    tick();
    check("s4_rsp0_valid", 64'(hp_rsp_valid), 64'h1);
    check("s4_rsp0_id", 64'(hp_rsp_id), 64'h0);
    check("s4_rsp0_data", 64'(hp_rsp_data), 64'h00001234);
    $display("s4 rsp: id=%0d data=%08h", hp_rsp_id, hp_rsp_data);
    tick();

    // Scenario 5: grant then reset one cycle later
    req_valid = 4'b0100; set_addr(2, 8'h20);
    #1;
    check("s5_grant", 64'(hp_ready), 64'b0100);
    tick();
    rst_n = 1'b0; req_valid = 4'b1111;
    for (int i = 0; i < N; i++) set_addr(i, 8'(8'h40 + i));
    #1;
    check("s5_rst_ready", 64'(hp_ready), 64'h0);
    check("s5_rst_enb", 64'(hp_enb), 64'h0);
    check("s5_rst_regceb", 64'(hp_regceb), 64'h0);
    check("s5_rst_rsp_valid", 64'(hp_rsp_valid), 64'h0);
    $display("s5 reset: ready=%b regceb=%b", hp_ready, hp_regceb);
    tick();
    check("s5_rst_no_rsp", 64'(hp_rsp_valid), 64'h0);
    rst_n = 1'b1;

    // Scenario 3: all four valid for 16 cycles, starting right after release
    for (int i = 0; i < N; i++) gcount[i] = 0;
    for (int k = 0; k < 19; k++) begin
      req_valid = (k < 16) ? 4'b1111 : 4'b0000;
      #1;
      if (k < 16) begin
        check($sformatf("s3_grant_c%0d", k), 64'(hp_ready), 64'(4'b0001 << (k % 4)));
        for (int i = 0; i < N; i++) if (hp_ready[i]) gcount[i]++;
      end
      if (k >= 2 && k < 18) begin
        check($sformatf("s3_rsp_valid_c%0d", k), 64'(hp_rsp_valid), 64'h1);
        check($sformatf("s3_rsp_id_c%0d", k), 64'(hp_rsp_id), 64'((k - 2) % 4));
        check($sformatf("s3_rsp_data_c%0d", k), 64'(hp_rsp_data), 64'(32'h1000 + (k - 2) % 4));
      end else begin
        check($sformatf("s3_no_rsp_c%0d", k), 64'(hp_rsp_valid), 64'h0);
      end
      $display("s3 cycle %0d: ready=%b rsp_valid=%b rsp_id=%0d", k, hp_ready, hp_rsp_valid, hp_rsp_id);
      tick();
    end
    for (int i = 0; i < N; i++) begin
      check($sformatf("s3_count_req%0d", i), 64'(gcount[i]), 64'd4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdp_bram_rd_arbiter.md
Name: sdp_bram_rd_arbiter

Overview:
Round-robin arbiter sharing the single read port of an sdp_bram instance among NUM_REQ requesters; the write port passes through. Grants at most one read per cycle and tracks the BRAM read latency with a valid/ID shift pipeline. Returns each result tagged with the requester ID. Holds a read whose address collides with a same-cycle write, so requesters never receive pre-write data.

Parameters:
NUM_REQ, 4, number of read requesters (2..16)
RAM_WIDTH, 32, BRAM data width
RAM_DEPTH, 256, BRAM depth; ADDR_W = clogb2(RAM_DEPTH-1)
RAM_PERFORMANCE, "HIGH_PERFORMANCE", must match the BRAM; sets RD_LAT = 2, "LOW_LATENCY" sets RD_LAT = 1
ID_W, clogb2(NUM_REQ-1), response ID width (minimum 1)

Ports:
clka  in  1  clock, shared with the BRAM
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester read request
req_addr  in  NUM_REQ*ADDR_W  packed read addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when valid and ready are both high
wr_en  in  1  write strobe
wr_addr  in  ADDR_W  write address
wr_data  in  RAM_WIDTH  write data
bram_wea  out  1  = wr_en
bram_addra  out  ADDR_W  = wr_addr
bram_dina  out  RAM_WIDTH  = wr_data
bram_enb  out  1  read enable, high in the grant cycle
bram_addrb  out  ADDR_W  address of the granted requester
bram_regceb  out  1  high when pipeline stage 1 is valid (HIGH_PERFORMANCE only), otherwise 0
bram_rstb  out  1  = ~rst_n
bram_doutb  in  RAM_WIDTH  BRAM read data
rsp_valid  out  1  response strobe; no backpressure, so the consumer must accept it
rsp_id  out  ID_W  requester index of the response
rsp_data  out  RAM_WIDTH  = bram_doutb; meaningful only while rsp_valid is high

Behaviour:
- Reset (async assert, sync release): req_ready = 0, bram_enb = 0, bram_regceb = 0, rsp_valid = 0, rsp_id = 0, all pipeline valids = 0, rr_ptr = NUM_REQ-1 so requester 0 has first priority.
- Eligibility: eligible[i] = req_valid[i] and not (wr_en and req_addr[i] == wr_addr).
- Grant: combinational. Choose the first eligible index searching cyclically from rr_ptr+1, wrapping modulo NUM_REQ.
  - req_ready = one-hot of the chosen index; all zeros if nothing is eligible.
  - bram_enb = |req_ready.
  - bram_addrb = req_addr of the winner; hold the last value when idle.
- rr_ptr updates to the winner index on a grant and holds when idle.
- A held (collided) requester stays eligible next cycle; its request is not dropped.
- Pipeline: stage[0] = {grant, winner id}, shifted every cycle for RD_LAT stages.
  - rsp_valid and rsp_id come from the last stage.
  - A grant in cycle T gives rsp_valid in cycle T+RD_LAT, with the data of that address as of the end of cycle T-1 (read-first semantics).
- Throughput: one grant per cycle, back-to-back, no bubbles. With all NUM_REQ requesters continuously valid, each one is granted exactly once every NUM_REQ cycles.
- Write port: purely combinational pass-through. Writes are never stalled.
- Reset mid-flight: in-flight reads are discarded and no rsp_valid is issued for them; bram_rstb clears the BRAM output register.
- req_valid deasserted without a grant: the request is withdrawn, which is legal. req_addr must stay stable while valid and not ready.

Decomposition:
- Shared package/header sdp_ctrl_pkg holds:
  - the clogb2 function
  - the RD_LAT derivation from RAM_PERFORMANCE
  - the packed-address slice macro
- Sub-module rr_arbiter (NUM_REQ parameter): inputs eligible and rr_ptr, outputs one-hot grant and winner index. It is purely combinational, and the pointer register lives in the parent.

Test Plan:
- HIGH_PERFORMANCE, BRAM preloaded with addr 0x05 = 0xDEADBEEF; req_valid = 4'b0001, addr 0x05 at cycle 10 -> req_ready[0] at cycle 10; rsp_valid, rsp_id = 0, rsp_data = 0xDEADBEEF at cycle 12.
- Requesters 1 and 2 valid together from reset, addresses 0x10 and 0x20 -> grant 1 then 2 on consecutive cycles; responses in the same order, IDs 1 and 2, two cycles after each grant.
- All 4 valid for 16 cycles -> grant order 0,1,2,3 repeating; exactly 4 grants per requester; rsp_valid high for 16 consecutive cycles.
- wr_en = 1, wr_addr = 0x30, wr_data = 0x1234 while req 0 reads 0x30 and req 1 reads 0x31 -> req 1 granted that cycle, req 0 granted the next cycle; req 0 response data = 0x1234.
- Grant issued, then rst_n pulsed low one cycle later -> outputs at reset values immediately; no rsp_valid afterwards; first grant after release goes to requester 0.
- RAM_PERFORMANCE = "LOW_LATENCY", repeat scenario 1 -> rsp_valid at cycle 11; bram_regceb stays 0.
